// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter in front of a single-cycle SLT/SLTU comparator.
// One request in flight at a time: IDLE (grant) -> CMP (evaluate) -> RESP (hold until taken).
module cmp_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic             req0_signed,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic             req1_signed,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_Result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_last_grant;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_id;
    logic               r_rsp_id;
    logic               r_rsp_result;

    logic               w_any_valid;
    logic               w_grant1;
    logic               w_take;
    logic               w_lt;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_sel_signed;

    // Contested cycles go to the requester not served last; a lone requester always wins.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant1 = ~r_last_grant;
        end else begin
            w_grant1 = req1_valid;
        end
        w_sel_a      = w_grant1 ? req1_A      : req0_A;
        w_sel_b      = w_grant1 ? req1_B      : req0_B;
        w_sel_signed = w_grant1 ? req1_signed : req0_signed;
    end

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp_valid   = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst && w_any_valid) begin
                    req0_ready  = ~w_grant1;
                    req1_ready  = w_grant1;
                    w_take      = 1'b1;
                    w_state_nxt = CMP;
                end
            end
            CMP: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        if (r_signed) begin
            w_lt = $signed(r_a) < $signed(r_b);
        end else begin
            w_lt = r_a < r_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_signed     <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_signed     <= w_sel_signed;
                r_id         <= w_grant1;
                r_last_grant <= w_grant1;
            end
            if (r_state == CMP) begin
                r_rsp_result <= w_lt;
                r_rsp_id     <= r_id;
            end
        end
    end

    assign rsp_id     = r_rsp_id;
    assign rsp_Result = r_rsp_result;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios followed by randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_cmp_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_signed;
    logic [W-1:0] req0_A, req0_B;
    logic         req1_valid, req1_ready, req1_signed;
    logic [W-1:0] req1_A, req1_B;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_Result;

    always #5 clk = ~clk;

    cmp_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_A      (req0_A),
        .req0_B      (req0_B),
        .req0_signed (req0_signed),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_A      (req1_A),
        .req1_B      (req1_B),
        .req1_signed (req1_signed),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_Result  (rsp_Result)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: one transaction in flight, aged in cycles since its acceptance.
    bit          m_busy;
    int unsigned m_age;
    bit          m_last;
    bit          m_res, m_id;
    bit          p_res, p_id;
    bit          acc0, acc1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_lt(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] ka, kb;
        ka = a;
        kb = b;
        if (s) begin
            ka[W-1] = ~ka[W-1];
            kb[W-1] = ~kb[W-1];
        end
        return ka < kb;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 7)
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom % 16);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Inputs are already driven for this cycle; compare, advance the model, move to next cycle.
    task automatic tick();
        bit e_r0, e_r1, win;
        #1;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!rst && !m_busy && (req0_valid || req1_valid)) begin
            win  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = !win;
            e_r1 = win;
        end
        check("req0_ready", 64'(req0_ready), 64'(e_r0));
        check("req1_ready", 64'(req1_ready), 64'(e_r1));
        check("rsp_valid",  64'(rsp_valid),  64'(m_busy && m_age >= 2));
        check("rsp_Result", 64'(rsp_Result), 64'(m_res));
        check("rsp_id",     64'(rsp_id),     64'(m_id));
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_res  = 1'b0;
            m_id   = 1'b0;
        end else if (!m_busy) begin
            if (e_r0 || e_r1) begin
                m_busy = 1'b1;
                m_age  = 1;
                p_id   = e_r1;
                p_res  = e_r1 ? ref_lt(req1_A, req1_B, req1_signed)
                              : ref_lt(req0_A, req0_B, req0_signed);
                m_last = e_r1;
                acc0   = e_r0;
                acc1   = e_r1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
            m_res = p_res;
            m_id  = p_id;
        end else if (rsp_ready) begin
            m_busy = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst        = 1'b0;
        rsp_ready  = 1'b1;
    endtask

    task automatic txn(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit s, input bit exp_res, input string tag);
        quiet();
        if (id) begin
            req1_valid = 1'b1; req1_A = a; req1_B = b; req1_signed = s;
        end else begin
            req0_valid = 1'b1; req0_A = a; req0_B = b; req0_signed = s;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_A = ~a;
        req1_A = ~a;
        tick();
        #1;
        check({tag, "_valid"}, 64'(rsp_valid),  64'd1);
        check({tag, "_res"},   64'(rsp_Result), 64'(exp_res));
        check({tag, "_id"},    64'(rsp_id),     64'(id));
        tick();
    endtask

    initial begin
        bit grants[$];

        rst = 1'b1;
        req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_signed = 1'b0;
        req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_signed = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_res = 1'b0; m_id = 1'b0;
        p_res = 1'b0; p_id = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        tick();

        txn(1'b0, 64'd5, 64'hA, 1'b0, 1'b1, "sltu_basic");
        txn(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "max_min_u");
        txn(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0, "max_min_s");
        txn(1'b0, '1, '1, 1'b0, 1'b0, "eq_u");
        txn(1'b1, '1, '1, 1'b1, 1'b0, "eq_s");
        txn(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b1, 1'b1, "neg_pos_s");

        // Contention straight after reset: grants must alternate starting with requester 0.
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req0_A = rnd_op(); req0_B = rnd_op(); req0_signed = 1'($urandom);
            req1_A = rnd_op(); req1_B = rnd_op(); req1_signed = 1'($urandom);
            #1;
            if (req0_ready) grants.push_back(1'b0);
            if (req1_ready) grants.push_back(1'b1);
            tick();
        end
        check("rr_count", 64'(grants.size()), 64'd4);
        foreach (grants[i]) check("rr_grant", 64'(grants[i]), 64'(i % 2));
        quiet();
        for (int i = 0; i < 3; i++) tick();

        // Backpressure with requester 1 waving new operands while a response is held.
        req0_valid = 1'b1; req0_A = 64'd3; req0_B = 64'd2; req0_signed = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        rsp_ready  = 1'b0;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req1_A = rnd_op(); req1_B = rnd_op(); req1_signed = 1'($urandom);
            tick();
        end
        #1;
        check("bp_held_valid", 64'(rsp_valid), 64'd1);
        check("bp_held_res",   64'(rsp_Result), 64'd0);
        rsp_ready = 1'b1;
        tick();
        #1;
        check("bp_req1_taken", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Reset during CMP drops the compare; next contested grant returns to requester 0.
        req1_valid = 1'b1; req1_A = 64'd1; req1_B = 64'd9; req1_signed = 1'b0;
        tick();
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        #1;
        check("rst_no_rsp", 64'(rsp_valid), 64'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_grant0", 64'(req0_ready), 64'd1);
        tick();
        quiet();
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic; a raised valid is held until its handshake.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 64) == 0;
            if (!req0_valid || acc0) req0_valid = ($urandom % 3) != 0;
            if (!req1_valid || acc1) req1_valid = ($urandom % 3) != 0;
            req0_A = rnd_op();
            req0_B = (($urandom % 5) == 0) ? req0_A : rnd_op();
            req0_signed = 1'($urandom);
            req1_A = rnd_op();
            req1_B = (($urandom % 5) == 0) ? req1_A : rnd_op();
            req1_signed = 1'($urandom);
            rsp_ready = ($urandom % 3) != 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
